// File: rtl/cv32e40x_obi_fetch_bridge.sv
// Fetch-side valid/ready to OBI A-channel bridge with bounded outstanding count.
// Optional protocol checker enabled by defining CV32E40X_OBI_PROTO_CHECK_EN.
module cv32e40x_obi_fetch_bridge #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trans_valid_i,
    output logic              trans_ready_o,
    input  logic [ADDR_W-1:0] trans_addr_i,
    input  logic [2:0]        trans_prot_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              obi_req_o,
    input  logic              obi_gnt_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic [2:0]        obi_prot_o,
    input  logic              obi_rvalid_i,
    input  logic [31:0]       obi_rdata_i,
    input  logic              obi_err_i,
    output logic [2:0]        outstanding_o,
    output logic              proto_err_o
);

    typedef enum logic {StTransparent, StRegistered} state_e;

    localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        prot_q, prot_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              issue, retire;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        prot_d        = prot_q;
        trans_ready_o = 1'b0;
        obi_req_o     = 1'b0;
        obi_addr_o    = trans_addr_i;
        obi_prot_o    = trans_prot_i;
        unique case (state_q)
            StTransparent: begin
                trans_ready_o = (cnt_q < MaxCnt);
                obi_req_o     = trans_valid_i & trans_ready_o;
                // Ungranted request: freeze payload so it stays stable until grant.
                if (obi_req_o && !obi_gnt_i) begin
                    state_d = StRegistered;
                    addr_d  = trans_addr_i;
                    prot_d  = trans_prot_i;
                end
            end
            StRegistered: begin
                obi_req_o  = 1'b1;
                obi_addr_o = addr_q;
                obi_prot_o = prot_q;
                if (obi_gnt_i) begin
                    state_d = StTransparent;
                end
            end
        endcase
    end

    assign issue  = obi_req_o & obi_gnt_i;
    // A response with nothing outstanding cannot underflow the count.
    assign retire = obi_rvalid_i & (cnt_q != 3'd0);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({issue, retire})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StTransparent;
            addr_q  <= '0;
            prot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign resp_valid_o  = obi_rvalid_i;
    assign resp_rdata_o  = obi_rdata_i;
    assign resp_err_o    = obi_err_i;

`ifdef CV32E40X_OBI_PROTO_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if ((obi_rvalid_i && (cnt_q == 3'd0)) || (obi_gnt_i && !obi_req_o)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign proto_err_o = perr_q;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40x_obi_fetch_bridge.sv
// Directed bench for the OBI fetch bridge; a queue-based bus model is checked every cycle.
module tb_cv32e40x_obi_fetch_bridge;

    localparam int unsigned MaxOut = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trans_valid, trans_ready;
    logic [31:0] trans_addr;
    logic [2:0]  trans_prot;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        obi_req, obi_gnt;
    logic [31:0] obi_addr;
    logic [2:0]  obi_prot;
    logic        obi_rvalid, obi_err;
    logic [31:0] obi_rdata;
    logic [2:0]  outstanding;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    cv32e40x_obi_fetch_bridge #(
        .ADDR_W         (32),
        .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trans_valid_i(trans_valid),
        .trans_ready_o(trans_ready),
        .trans_addr_i (trans_addr),
        .trans_prot_i (trans_prot),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_prot_o   (obi_prot),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .obi_err_i    (obi_err),
        .outstanding_o(outstanding),
        .proto_err_o  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus model: granted-unanswered addresses in a queue, plus one held (ungranted) request.
    logic [31:0] m_q[$];
    logic        m_held;
    logic [31:0] m_haddr;
    logic [2:0]  m_hprot;
    logic        m_perr;

    always @(negedge clk) begin
        logic        e_ready, e_req, spurious;
        logic [31:0] e_addr;
        logic [2:0]  e_prot;
        if (!rst_n) begin
            m_q.delete();
            m_held = 1'b0;
            m_haddr = '0;
            m_hprot = '0;
            m_perr = 1'b0;
        end else begin
            e_ready = !m_held && (m_q.size() < MaxOut);
            e_req   = m_held ? 1'b1 : (trans_valid && e_ready);
            e_addr  = m_held ? m_haddr : trans_addr;
            e_prot  = m_held ? m_hprot : trans_prot;
            chk("trans_ready", {31'd0, trans_ready}, {31'd0, e_ready});
            chk("obi_req", {31'd0, obi_req}, {31'd0, e_req});
            if (e_req) begin
                chk("obi_addr", obi_addr, e_addr);
                chk("obi_prot", {29'd0, obi_prot}, {29'd0, e_prot});
            end
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, obi_rvalid});
            if (obi_rvalid) begin
                chk("resp_rdata", resp_rdata, obi_rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, obi_err});
            end
            chk("outstanding", {29'd0, outstanding}, 32'(m_q.size()));
`ifdef CV32E40X_OBI_PROTO_CHECK_EN
            chk("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
`else
            chk("proto_err", {31'd0, proto_err}, 32'd0);
`endif
            spurious = obi_rvalid && (m_q.size() == 0);
            if (spurious || (obi_gnt && !e_req)) m_perr = 1'b1;
            if (e_req && obi_gnt) begin
                m_q.push_back(e_addr);
                m_held = 1'b0;
            end else if (e_req) begin
                m_held  = 1'b1;
                m_haddr = e_addr;
                m_hprot = e_prot;
            end
            if (obi_rvalid && !spurious) void'(m_q.pop_front());
        end
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trans_valid = 1'b0;
        obi_gnt     = 1'b0;
        obi_rvalid  = 1'b0;
        obi_err     = 1'b0;
    endtask

    logic perr_exp;

    initial begin
`ifdef CV32E40X_OBI_PROTO_CHECK_EN
        perr_exp = 1'b1;
`else
        perr_exp = 1'b0;
`endif
        rst_n = 1'b0;
        idle();
        trans_addr = '0;
        trans_prot = '0;
        obi_rdata  = '0;
        cyc();
        cyc();
        chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_ready", {31'd0, trans_ready}, 32'd1);
        rst_n = 1'b1;
        cyc();

        // Zero-wait grant then response.
        trans_valid = 1'b1; trans_addr = 32'h100; trans_prot = 3'b101; obi_gnt = 1'b1;
        #1;
        chk("zw_req", {31'd0, obi_req}, 32'd1);
        chk("zw_addr", obi_addr, 32'h100);
        cyc();
        idle();
        #1;
        chk("zw_out1", {29'd0, outstanding}, 32'd1);
        cyc();
        obi_rvalid = 1'b1; obi_rdata = 32'hDEAD_BEEF;
        #1;
        chk("zw_rvalid", {31'd0, resp_valid}, 32'd1);
        chk("zw_rdata", resp_rdata, 32'hDEAD_BEEF);
        cyc();
        idle();
        #1;
        chk("zw_out0", {29'd0, outstanding}, 32'd0);

        // Grant stall with upstream address change.
        cyc();
        trans_valid = 1'b1; trans_addr = 32'h200; trans_prot = 3'b010;
        cyc();
        trans_addr = 32'h300;
        #1;
        chk("st_req", {31'd0, obi_req}, 32'd1);
        chk("st_addr", obi_addr, 32'h200);
        chk("st_ready", {31'd0, trans_ready}, 32'd0);
        cyc();
        cyc();
        obi_gnt = 1'b1;
        #1;
        chk("st_gnt_addr", obi_addr, 32'h200);
        cyc();
        idle();
        #1;
        chk("st_out1", {29'd0, outstanding}, 32'd1);
        chk("st_ready1", {31'd0, trans_ready}, 32'd1);
        cyc();
        obi_rvalid = 1'b1; obi_rdata = 32'h1234_5678;
        cyc();
        idle();

        // Outstanding limit.
        trans_valid = 1'b1; trans_addr = 32'h400; obi_gnt = 1'b1;
        cyc();
        trans_addr = 32'h404;
        cyc();
        trans_addr = 32'h408; obi_gnt = 1'b0;
        #1;
        chk("lim_out2", {29'd0, outstanding}, 32'd2);
        chk("lim_ready0", {31'd0, trans_ready}, 32'd0);
        chk("lim_req0", {31'd0, obi_req}, 32'd0);
        obi_rvalid = 1'b1; obi_rdata = 32'hA5A5_0001;
        #1;
        chk("lim_ready_same", {31'd0, trans_ready}, 32'd0);
        cyc();
        #1;
        chk("lim_out1", {29'd0, outstanding}, 32'd1);
        chk("lim_ready1", {31'd0, trans_ready}, 32'd1);
        // Simultaneous grant and response at count 1.
        obi_gnt = 1'b1; obi_rvalid = 1'b1; obi_rdata = 32'hA5A5_0002;
        cyc();
        idle();
        #1;
        chk("sim_out1", {29'd0, outstanding}, 32'd1);

        // Error response.
        obi_rvalid = 1'b1; obi_err = 1'b1; obi_rdata = 32'h0000_0BAD;
        #1;
        chk("err_resp", {31'd0, resp_err}, 32'd1);
        cyc();
        idle();
        #1;
        chk("err_out0", {29'd0, outstanding}, 32'd0);

        // Spurious response at count 0.
        obi_rvalid = 1'b1; obi_rdata = 32'hFFFF_0000;
        cyc();
        idle();
        #1;
        chk("pe_set", {31'd0, proto_err}, {31'd0, perr_exp});
        chk("pe_out0", {29'd0, outstanding}, 32'd0);
        cyc();
        cyc();
        chk("pe_held", {31'd0, proto_err}, {31'd0, perr_exp});
        rst_n = 1'b0;
        #1;
        chk("pe_clr", {31'd0, proto_err}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Grant without request.
        obi_gnt = 1'b1;
        cyc();
        idle();
        #1;
        chk("gnr_set", {31'd0, proto_err}, {31'd0, perr_exp});
        chk("gnr_out0", {29'd0, outstanding}, 32'd0);

        // Reset while a request is held.
        trans_valid = 1'b1; trans_addr = 32'h500; trans_prot = 3'b001;
        cyc();
        cyc();
        rst_n = 1'b0; trans_valid = 1'b0;
        #1;
        chk("rr_req0", {31'd0, obi_req}, 32'd0);
        chk("rr_out0", {29'd0, outstanding}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        trans_valid = 1'b1; trans_addr = 32'h600; obi_gnt = 1'b1;
        #1;
        chk("rr_addr", obi_addr, 32'h600);
        cyc();
        idle();
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
